oklab2oklch: RTL and testbench

- Pipelined polar converter that sits directly downstream of the YCbCr-to-OkLab stage.
- Consumes OkLab pixels (L 0.15 unsigned, a/b S0.13) and produces OkLCh:
  - L passes through delay-matched.
  - Chroma C = sqrt(a²+b²).
  - Hue H = atan2(b,a), expressed as an unsigned fraction of a full turn.
- Uses a vectoring CORDIC, one iteration per pipeline stage, one pixel per clock, no back-pressure.
- hstr/hend/href are delayed to match the data.

---
 rtl/oklab2oklch.sv | 170 +++++++++++++++++
 tb/tb_oklab2oklch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/oklab2oklch.sv
// OkLab -> OkLCh polar converter: vectoring CORDIC, one iteration per stage, one pixel per clock.
// L and the line strobes are delay-matched to the chroma/hue result (LAT = ITER + 2 cycles).
module oklab2oklch #(
    parameter int CIPW_L  = 15,
    parameter int CIPW_AB = 13,
    parameter int COW_C   = 14,
    parameter int COW_H   = 12,
    parameter int ITER    = 12,
    parameter int GRD     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CIPW_L-1:0]  i_data_l,
    input  logic [CIPW_AB-1:0] i_data_a_sgn,
    input  logic [CIPW_AB-1:0] i_data_b_sgn,
    input  logic               i_hstr,
    input  logic               i_hend,
    input  logic               i_href,
    output logic [CIPW_L-1:0]  o_data_l,
    output logic [COW_C-1:0]   o_data_c,
    output logic [COW_H-1:0]   o_data_h,
    output logic               o_hstr,
    output logic               o_hend,
    output logic               o_href
);
    localparam int LAT = ITER + 2;
    localparam int XW  = CIPW_AB + 2 + GRD;
    localparam int ZW  = COW_H + GRD + 1;
    localparam int PW  = XW + 17;
    localparam int SH  = 16 + GRD;

    localparam logic signed [PW-1:0] KC     = PW'(39797);
    localparam logic signed [PW-1:0] C_RND  = PW'(2 ** (SH - 1));
    localparam logic signed [PW-1:0] C_MAX  = PW'(2 ** COW_C - 1);
    localparam logic signed [ZW-1:0] H_RND  = ZW'(2 ** (GRD - 1));
    localparam logic signed [ZW-1:0] Z_HALF = ZW'(2 ** (COW_H + GRD - 1));

    // atan(2^-i) as a fraction of a full turn, scaled by 2^15 (COW_H + GRD = 15).
    function automatic logic signed [ZW-1:0] atan_lut(input int idx);
        logic signed [ZW-1:0] v;
        case (idx)
            0:       v = ZW'(4096);
            1:       v = ZW'(2418);
            2:       v = ZW'(1278);
            3:       v = ZW'(649);
            4:       v = ZW'(326);
            5:       v = ZW'(163);
            6:       v = ZW'(81);
            7:       v = ZW'(41);
            8:       v = ZW'(20);
            9:       v = ZW'(10);
            10:      v = ZW'(5);
            11:      v = ZW'(3);
            12:      v = ZW'(1);
            13:      v = ZW'(1);
            default: v = '0;
        endcase
        return v;
    endfunction

    logic signed [XW-1:0] r_x  [0:ITER];
    logic signed [XW-1:0] r_y  [0:ITER-1];
    logic signed [ZW-1:0] r_z  [0:ITER];
    logic                 r_zf [0:ITER];
    logic [CIPW_L-1:0]    r_l  [0:LAT-1];
    logic [2:0]           r_sb [0:LAT-1];
    logic signed [PW-1:0] r_prod;
    logic [COW_H-1:0]     r_h;
    logic                 r_p_zf;

    logic signed [XW-1:0] w_a_ext;
    logic signed [XW-1:0] w_b_ext;
    logic                 w_neg;
    logic signed [ZW-1:0] w_h_rnd;
    logic signed [PW-1:0] w_c_full;
    logic [COW_C-1:0]     w_c;

    assign w_a_ext  = XW'(signed'(i_data_a_sgn)) <<< GRD;
    assign w_b_ext  = XW'(signed'(i_data_b_sgn)) <<< GRD;
    assign w_neg    = i_data_a_sgn[CIPW_AB-1];
    assign w_h_rnd  = r_z[ITER] + H_RND;
    assign w_c_full = (r_prod + C_RND) >>> SH;

    always_comb begin
        w_c = COW_C'(w_c_full);
        if (w_c_full > C_MAX) begin
            w_c = '1;
        end else if (w_c_full < 0) begin
            w_c = '0;
        end
    end

    // Left half-plane is folded by negation; the half turn is preloaded into z.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= ITER; i++) begin
                r_x[i]  <= '0;
                r_z[i]  <= '0;
                r_zf[i] <= 1'b0;
            end
            for (int i = 0; i < ITER; i++) begin
                r_y[i] <= '0;
            end
        end else begin
            r_x[0]  <= w_neg ? -w_a_ext : w_a_ext;
            r_y[0]  <= w_neg ? -w_b_ext : w_b_ext;
            r_z[0]  <= w_neg ? Z_HALF : '0;
            r_zf[0] <= (i_data_a_sgn == '0) && (i_data_b_sgn == '0);
            for (int i = 0; i < ITER; i++) begin
                if (!r_y[i][XW-1]) begin
                    r_x[i+1] <= r_x[i] + (r_y[i] >>> i);
                    r_z[i+1] <= r_z[i] + atan_lut(i);
                end else begin
                    r_x[i+1] <= r_x[i] - (r_y[i] >>> i);
                    r_z[i+1] <= r_z[i] - atan_lut(i);
                end
                r_zf[i+1] <= r_zf[i];
            end
            // The final y residue is never consumed, so the last stage drops it.
            for (int i = 0; i < ITER - 1; i++) begin
                if (!r_y[i][XW-1]) begin
                    r_y[i+1] <= r_y[i] - (r_x[i] >>> i);
                end else begin
                    r_y[i+1] <= r_y[i] + (r_x[i] >>> i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_l[i]  <= '0;
                r_sb[i] <= '0;
            end
        end else begin
            r_l[0]  <= i_data_l;
            r_sb[0] <= {i_hstr, i_hend, i_href};
            for (int i = 1; i < LAT; i++) begin
                r_l[i]  <= r_l[i-1];
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    // Gain compensation multiply and hue rounding, then saturate/gate at the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod   <= '0;
            r_h      <= '0;
            r_p_zf   <= 1'b0;
            o_data_l <= '0;
            o_data_c <= '0;
            o_data_h <= '0;
            o_hstr   <= 1'b0;
            o_hend   <= 1'b0;
            o_href   <= 1'b0;
        end else begin
            r_prod   <= PW'(r_x[ITER]) * KC;
            r_h      <= COW_H'(w_h_rnd >>> GRD);
            r_p_zf   <= r_zf[ITER];
            o_data_l <= r_sb[LAT-1][0] ? r_l[LAT-1] : '0;
            o_data_c <= (r_sb[LAT-1][0] && !r_p_zf) ? w_c : '0;
            o_data_h <= (r_sb[LAT-1][0] && !r_p_zf) ? r_h : '0;
            o_hstr   <= r_sb[LAT-1][2];
            o_hend   <= r_sb[LAT-1][1];
            o_href   <= r_sb[LAT-1][0];
        end
    end
endmodule

// File: tb/tb_oklab2oklch.sv
// Directed bench for oklab2oklch: every cycle's outputs are compared against the inputs
// recorded LAT cycles earlier, with hand-computed chroma/hue and reset kill tracking.
module tb_oklab2oklch;
    localparam int LAT = 14;
    localparam int NH  = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] i_data_l;
    logic [12:0] i_data_a_sgn;
    logic [12:0] i_data_b_sgn;
    logic        i_hstr;
    logic        i_hend;
    logic        i_href;
    logic [14:0] o_data_l;
    logic [13:0] o_data_c;
    logic [11:0] o_data_h;
    logic        o_hstr;
    logic        o_hend;
    logic        o_href;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int cur_c, cur_ct, cur_h, cur_ht;
    bit cur_hw;

    bit h_hs [NH];
    bit h_he [NH];
    bit h_hr [NH];
    bit h_hw [NH];
    bit h_kill [NH];
    int h_l  [NH];
    int h_c  [NH];
    int h_ct [NH];
    int h_h  [NH];
    int h_ht [NH];

    always #5 clk = ~clk;

    oklab2oklch dut (
        .clk          (clk),
        .rst          (rst),
        .i_data_l     (i_data_l),
        .i_data_a_sgn (i_data_a_sgn),
        .i_data_b_sgn (i_data_b_sgn),
        .i_hstr       (i_hstr),
        .i_hend       (i_hend),
        .i_href       (i_href),
        .o_data_l     (o_data_l),
        .o_data_c     (o_data_c),
        .o_data_h     (o_data_h),
        .o_hstr       (o_hstr),
        .o_hend       (o_hend),
        .o_href       (o_href)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === 32'(exp)) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp, input int tol,
                              input bit circ);
        int d;
        d = obs - exp;
        if (circ) begin
            d = ((d % 4096) + 4096) % 4096;
            if (d > 2048) d = 4096 - d;
        end else if (d < 0) begin
            d = -d;
        end
        total++;
        assert (d <= tol) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0d want=%0d+-%0d", tag, cyc, obs, exp, tol);
        end
    endtask

    task automatic check_wrap(input string tag, input int obs);
        total++;
        assert ((obs === 4095) || (obs === 0)) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0d want=4095or0", tag, cyc, obs);
        end
    endtask

    task automatic check_cycle(input int e);
        bit live;
        live = 1'b0;
        if (e >= 0) live = !h_kill[e];
        if (!live) begin
            check_eq("hstr_z", o_hstr, 0);
            check_eq("hend_z", o_hend, 0);
            check_eq("href_z", o_href, 0);
            check_eq("l_z", o_data_l, 0);
            check_eq("c_z", o_data_c, 0);
            check_eq("h_z", o_data_h, 0);
        end else begin
            check_eq("hstr", o_hstr, int'(h_hs[e]));
            check_eq("hend", o_hend, int'(h_he[e]));
            check_eq("href", o_href, int'(h_hr[e]));
            if (h_hr[e]) begin
                check_eq("l", o_data_l, h_l[e]);
                check_near("c", int'(o_data_c), h_c[e], h_ct[e], 1'b0);
                if (h_hw[e]) check_wrap("h_wrap", int'(o_data_h));
                else check_near("h", int'(o_data_h), h_h[e], h_ht[e], 1'b1);
            end else begin
                check_eq("l_gate", o_data_l, 0);
                check_eq("c_gate", o_data_c, 0);
                check_eq("h_gate", o_data_h, 0);
            end
        end
    endtask

    task automatic tick();
        if (cyc >= NH) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NH);
            $fatal(1, "history exhausted");
        end
        h_hs[cyc]   = i_hstr;
        h_he[cyc]   = i_hend;
        h_hr[cyc]   = i_href;
        h_l[cyc]    = int'(i_data_l);
        h_c[cyc]    = cur_c;
        h_ct[cyc]   = cur_ct;
        h_h[cyc]    = cur_h;
        h_ht[cyc]   = cur_ht;
        h_hw[cyc]   = cur_hw;
        h_kill[cyc] = 1'b0;
        // A sampled reset wipes the output edge and everything still in flight.
        if (rst) begin
            for (int k = 0; k <= LAT; k++) begin
                if (cyc - k >= 0) h_kill[cyc-k] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_cycle(cyc - LAT);
        cyc++;
    endtask

    task automatic px(input int l, input int a, input int b, input bit hs, input bit he,
                      input int c, input int ct, input int h, input int ht, input bit hw);
        i_data_l     = 15'(l);
        i_data_a_sgn = 13'(a);
        i_data_b_sgn = 13'(b);
        i_hstr       = hs;
        i_hend       = he;
        i_href       = 1'b1;
        cur_c        = c;
        cur_ct       = ct;
        cur_h        = h;
        cur_ht       = ht;
        cur_hw       = hw;
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            i_data_l     = 15'($urandom);
            i_data_a_sgn = 13'($urandom);
            i_data_b_sgn = 13'($urandom);
            i_hstr       = 1'b0;
            i_hend       = 1'b0;
            i_href       = 1'b0;
            tick();
        end
    endtask

    // Pixels cycle through the four axes: hue 0, 1024, 2048, 3072 at chroma 2048.
    task automatic line(input int n, input int rst_at);
        int q;
        for (int k = 0; k < n; k++) begin
            q   = k % 4;
            rst = (k == rst_at);
            case (q)
                0:       px((k * 37) % 32768,  2048,     0, k == 0, k == n - 1, 2048, 2,    0, 2, 0);
                1:       px((k * 37) % 32768,     0,  2048, k == 0, k == n - 1, 2048, 2, 1024, 2, 0);
                2:       px((k * 37) % 32768, -2048,     0, k == 0, k == n - 1, 2048, 2, 2048, 2, 0);
                default: px((k * 37) % 32768,     0, -2048, k == 0, k == n - 1, 2048, 2, 3072, 2, 0);
            endcase
        end
        rst = 1'b0;
    endtask

    initial begin
        cur_c  = 0;
        cur_ct = 0;
        cur_h  = 0;
        cur_ht = 0;
        cur_hw = 1'b0;
        rst    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_data_l     = 15'($urandom);
            i_data_a_sgn = 13'($urandom);
            i_data_b_sgn = 13'($urandom);
            i_hstr       = 1'($urandom);
            i_hend       = 1'($urandom);
            i_href       = 1'b1;
            tick();
        end
        rst = 1'b0;

        px(16384,  2048,     0, 0, 0, 2048, 2,    0, 2, 0);
        idle(2);
        px(1000,      0,  2048, 0, 0, 2048, 2, 1024, 2, 0);
        idle(2);
        px(2000,  -2048,     0, 0, 0, 2048, 2, 2048, 2, 0);
        idle(2);
        px(3000,      0, -2048, 0, 0, 2048, 2, 3072, 2, 0);
        idle(2);
        px(32767, -4096, -4096, 0, 0, 5793, 2, 2560, 2, 0);
        idle(2);
        px(5,     -4096,     0, 0, 0, 4096, 2, 2048, 2, 0);
        idle(2);
        px(777,       0,     0, 0, 0,    0, 0,    0, 0, 0);
        idle(2);
        px(12345,  2048,    -1, 0, 0, 2048, 2,    0, 0, 1);
        idle(LAT);

        line(640, -1);
        idle(1);
        line(640, -1);
        idle(1);
        px(4242, -4096, -4096, 1, 1, 5793, 2, 2560, 2, 0);
        idle(3);
        line(640, 300);
        idle(LAT + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
